// File: rtl/instruction_fetch.sv
// Instruction fetch: issues one imem read per cycle for pc, tags each read with its
// address, buffers returned words in an in-order FIFO and drops fetches killed by redirect.
module instruction_fetch #(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        redirect,
    output logic        fetch_stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic [OW-1:0] stale_cnt_q, stale_cnt_d;

    logic [31:0]   tag_q [MAX_OUTSTANDING];
    logic [TW-1:0] tag_wr_q, tag_wr_d;
    logic [TW-1:0] tag_rd_q, tag_rd_d;

    logic [31:0]   ins_mem_q [FIFO_DEPTH];
    logic [31:0]   pc_mem_q  [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [31:0] committed;
    logic        issue;
    logic        resp_accept;
    logic        resp_stale;
    logic        fifo_push;
    logic        fifo_pop;

    // Live reads already own a FIFO slot, so issue can never overflow the buffer.
    always_comb begin
        committed      = 32'(out_cnt_q) - 32'(stale_cnt_q) + 32'(fifo_cnt_q);
        imem_req_valid = reset
                         && (32'(out_cnt_q) < 32'(MAX_OUTSTANDING))
                         && (committed < 32'(FIFO_DEPTH));
        imem_req_addr  = {pc[31:2], 2'b00};
        issue          = imem_req_valid && imem_req_ready;
        fetch_stall    = !issue;

        resp_accept    = imem_resp_valid && (out_cnt_q != '0);
        resp_stale     = resp_accept && (stale_cnt_q != '0);
        fifo_push      = resp_accept && !resp_stale && !redirect;

        instr_valid    = (fifo_cnt_q != '0) && !redirect;
        fifo_pop       = instr_valid && instr_ready;
        instr          = ins_mem_q[rd_ptr_q];
        instr_pc       = pc_mem_q[rd_ptr_q];
    end

    always_comb begin
        out_cnt_d = out_cnt_q + OW'(issue) - OW'(resp_accept);

        stale_cnt_d = stale_cnt_q;
        if (redirect) begin
            stale_cnt_d = out_cnt_q - OW'(resp_accept);
        end else if (resp_stale) begin
            stale_cnt_d = stale_cnt_q - OW'(1);
        end

        tag_wr_d = tag_wr_q;
        if (issue) begin
            tag_wr_d = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TW'(1);
        end
        tag_rd_d = tag_rd_q;
        if (resp_accept) begin
            tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TW'(1);
        end

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (redirect) begin
            wr_ptr_d   = rd_ptr_q;
            fifo_cnt_d = '0;
        end else begin
            wr_ptr_d   = wr_ptr_q + FW'(fifo_push);
            rd_ptr_d   = rd_ptr_q + FW'(fifo_pop);
            fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_cnt_q   <= '0;
            stale_cnt_q <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_q[i] <= '0;
            end
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                ins_mem_q[i] <= '0;
                pc_mem_q[i]  <= '0;
            end
        end else begin
            out_cnt_q   <= out_cnt_d;
            stale_cnt_q <= stale_cnt_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            if (issue) begin
                tag_q[tag_wr_q] <= pc;
            end
            if (fifo_push) begin
                ins_mem_q[wr_ptr_q] <= imem_resp_data;
                pc_mem_q[wr_ptr_q]  <= tag_q[tag_rd_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (32'(out_cnt_d) <= 32'(MAX_OUTSTANDING))
                else $error("instruction_fetch: outstanding read count overflow");
            assert (stale_cnt_d <= out_cnt_d)
                else $error("instruction_fetch: stale count exceeds outstanding count");
            assert (!(fifo_push && !fifo_pop && (32'(fifo_cnt_q) == 32'(FIFO_DEPTH))))
                else $error("instruction_fetch: instruction buffer overflow");
        end
    end

endmodule
